// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the digit-serial BCD adder.
//   state_t  : controller states (IDLE / RUN / DONE)
//   BCD_W    : width of one packed-BCD digit
//   BCD_MAX  : largest legal BCD digit value
//   BCD_ADJ  : decimal adjust added when a digit sum exceeds BCD_MAX
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_digit_cell.sv
// ---------------------------------------------------------------------------
// bcd_digit_cell
// Combinational single-digit BCD adder.
// Ports:
//   x, y   in  [BCD_W-1:0]  addend digits
//   c      in  1            carry in
//   digit  out [BCD_W-1:0]  BCD sum digit
//   carry  out 1            decimal carry out
// Non-BCD inputs (>9) go through the same rule; the result is meaningless
// but deterministic, and the caller is expected to flag it.
// ---------------------------------------------------------------------------
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             c,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic [BCD_W:0] t;

    assign t = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, c};

    // Adding 6 in 4-bit arithmetic drops the 16 that the decimal carry
    // represents, giving (t+6) mod 16.
    always_comb begin
        digit = t[BCD_W-1:0];
        carry = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            digit = t[BCD_W-1:0] + BCD_ADJ;
            carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder
// Digit-serial packed-BCD adder: latches two DIGITS-digit operands on start
// and adds one digit per clock, least-significant first, through a single
// bcd_digit_cell. A carry register links consecutive digits.
// Ports:
//   clk      in   1           rising-edge clock
//   rst_n    in   1           asynchronous active-low reset
//   start    in   1           request pulse, sampled only in IDLE
//   a, b     in   4*DIGITS    packed-BCD operands
//   cin      in   1           carry into digit 0
//   busy     out  1           high while digits are being added
//   done     out  1           one-cycle pulse, result valid
//   sum      out  4*DIGITS    registered packed-BCD result
//   cout     out  1           registered carry out of the top digit
//   invalid  out  1           sticky: an operand digit exceeded 9
// ---------------------------------------------------------------------------
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    input  logic                    cin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     sum,
    output logic                    cout,
    output logic                    invalid
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                         state;
    logic [DIGITS-1:0][BCD_W-1:0]   a_r;
    logic [DIGITS-1:0][BCD_W-1:0]   b_r;
    logic [DIGITS-1:0][BCD_W-1:0]   sum_r;
    logic                           carry_r;
    logic [IDX_W-1:0]               idx;
    logic                           cout_r;
    logic                           invalid_r;

    logic [BCD_W-1:0]               a_dig;
    logic [BCD_W-1:0]               b_dig;
    logic [BCD_W-1:0]               cell_digit;
    logic                           cell_carry;

    assign a_dig = a_r[idx];
    assign b_dig = b_r[idx];

    bcd_digit_cell u_cell (
        .x     (a_dig),
        .y     (b_dig),
        .c     (carry_r),
        .digit (cell_digit),
        .carry (cell_carry)
    );

    // Controller and datapath registers. Operands are captured at start so
    // the inputs may change freely while the digits are being processed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            carry_r   <= 1'b0;
            idx       <= '0;
            cout_r    <= 1'b0;
            invalid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r       <= a;
                        b_r       <= b;
                        carry_r   <= cin;
                        idx       <= '0;
                        sum_r     <= '0;
                        cout_r    <= 1'b0;
                        invalid_r <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_r[idx] <= cell_digit;
                    carry_r    <= cell_carry;
                    invalid_r  <= invalid_r | (a_dig > BCD_MAX) | (b_dig > BCD_MAX);
                    idx        <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout_r <= cell_carry;
                        idx    <= '0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign sum     = sum_r;
    assign cout    = cout_r;
    assign invalid = invalid_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_adder
// Self-checking bench for bcd_serial_adder (DIGITS=4): a table of directed
// operations, hand-written multi-cycle sequences (start while busy, start
// during done, reset mid-operation) and random valid-BCD operations checked
// against a decimal-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         invalid;

    int vectors     = 0;
    int miscompares = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         cv;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_inv;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r = 0;
        for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] randBcd();
        logic [W-1:0] r;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Pulses start for one cycle, then scrambles the operand inputs so that
    // only the latched copies can produce the right answer. Returns at the
    // falling edge just after the start edge.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    // Waits (bounded) for done, counting busy cycles, then checks results and
    // that done lasts exactly one cycle with results held afterwards.
    task automatic checkOutput(input string name, input logic [W-1:0] exp_sum,
                               input logic exp_cout, input logic exp_inv);
        int  busy_cnt = 0;
        bit  seen     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " busy cycles"}, 32'(busy_cnt), 32'(DIGITS));
            check({name, " sum"},     32'(sum),     32'(exp_sum));
            check({name, " cout"},    32'(cout),    32'(exp_cout));
            check({name, " invalid"}, 32'(invalid), 32'(exp_inv));
            @(negedge clk);
            check({name, " done one cycle"}, 32'(done), 32'd0);
            check({name, " sum held"},       32'(sum),  32'(exp_sum));
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           total;
        int           done_cnt;
        logic [W-1:0] done_sum;

        tbl[0] = '{"basic",    16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        tbl[1] = '{"ripple",   16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{"maximum",  16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        // A+0 gives (10+6) mod 16 = 0 with carry into the 2 -> 3.
        tbl[3] = '{"invalid",  16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, 1'b1};
        tbl[4] = '{"inv clear",16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
        tbl[5] = '{"cin only", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        #12;
        check("reset busy",    32'(busy),    32'd0);
        check("reset done",    32'(done),    32'd0);
        check("reset sum",     32'(sum),     32'd0);
        check("reset cout",    32'(cout),    32'd0);
        check("reset invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].av, tbl[i].bv, tbl[i].cv);
            checkOutput(tbl[i].name, tbl[i].exp_sum, tbl[i].exp_cout, tbl[i].exp_inv);
        end

        // Second start two cycles into RUN must be ignored.
        @(negedge clk);
        a     = 16'h1111;
        b     = 16'h1111;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a     = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        done_sum = '0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                done_cnt++;
                done_sum = sum;
            end
            @(negedge clk);
        end
        check("busy start count", 32'(done_cnt), 32'd1);
        check("busy start sum",   32'(done_sum), 32'h2222);

        // A start raised during the done cycle is not sampled.
        applyStimulus(16'h0042, 16'h0058, 1'b0);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        check("done-cycle reach", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done-cycle start ignored", 32'(busy), 32'd0);
        check("done-cycle sum", 32'(sum), 32'h0100);

        // Asynchronous reset after digit 0 has been written.
        applyStimulus(16'h4321, 16'h1111, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset busy",    32'(busy),    32'd0);
        check("mid reset done",    32'(done),    32'd0);
        check("mid reset sum",     32'(sum),     32'd0);
        check("mid reset cout",    32'(cout),    32'd0);
        check("mid reset invalid", 32'(invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0005, 16'h0005, 1'b0);
        checkOutput("after reset", 16'h0010, 1'b0, 1'b0);

        // Random valid operands against decimal arithmetic.
        for (int i = 0; i < 40; i++) begin
            ra    = randBcd();
            rb    = randBcd();
            rc    = 1'($urandom);
            total = bcdToInt(ra) + bcdToInt(rb) + int'(rc);
            applyStimulus(ra, rb, rc);
            checkOutput($sformatf("random %0d", i), intToBcd(total % 10000),
                        1'(total >= 10000), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
